// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard_ctrl pipeline sequencing unit:
// FSM state encoding, forwarding select codes and the packed enable/flush bundle.
package hazard_pkg;

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        MEMWAIT = 3'd1,
        DRAIN   = 3'd2,
        HALTED  = 3'd3,
        ERROR   = 3'd4
    } state_e;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Enable/flush bundle, ordered to match the top-level output list.
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_FREEZE   = 7'b00000_00;
    localparam ctrl_t CTRL_RUN      = 7'b11111_00;
    localparam ctrl_t CTRL_BRANCH   = 7'b11111_11;
    localparam ctrl_t CTRL_LOAD_USE = 7'b00111_01;
    localparam ctrl_t CTRL_DRAIN    = 7'b01111_10;
    localparam ctrl_t CTRL_RESET    = 7'b01111_11;

    // State entered by a cycle that starts a memory wait. With a one-cycle
    // timeout that first unacknowledged cycle already exhausts the budget.
    function automatic state_e mem_wait_entry(input int unsigned timeout);
        if (timeout == 32'd1) begin
            return ERROR;
        end else begin
            return MEMWAIT;
        end
    endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational EX-operand forwarding compare for one source register.
// The younger producer (EX/MEM) takes precedence over MEM/WB; x0 never forwards.
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] ex_rs,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    output logic [1:0]            fwd_sel
);

    logic mem_hit_s;
    logic wb_hit_s;

    assign mem_hit_s = mem_reg_write && (mem_rd != {REG_ADDR_W{1'b0}}) && (mem_rd == ex_rs);
    assign wb_hit_s  = wb_reg_write  && (wb_rd  != {REG_ADDR_W{1'b0}}) && (wb_rd  == ex_rs);

    // Pick the operand source, newest result first.
    always_comb begin
        fwd_sel = FWD_REG;
        if (mem_hit_s) begin
            fwd_sel = FWD_MEM;
        end else if (wb_hit_s) begin
            fwd_sel = FWD_WB;
        end else begin
            fwd_sel = FWD_REG;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing unit for the 5-stage core: PC/stage enables, flushes,
// forwarding selects, load-use and memory-wait stalls, a memory timeout
// watchdog and a debug halt/drain handshake.
// Optional feature macro: HAZARD_PERF_CNT_EN builds the saturating
// stallCycles/flushCount counters; without it both outputs are tied to 0.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W   = 5,
    parameter int unsigned MEM_TIMEOUT  = 16,
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic [REG_ADDR_W-1:0] idRs1,
    input  logic [REG_ADDR_W-1:0] idRs2,
    input  logic                  idUsesRs1,
    input  logic                  idUsesRs2,
    input  logic [REG_ADDR_W-1:0] exRs1,
    input  logic [REG_ADDR_W-1:0] exRs2,
    input  logic [REG_ADDR_W-1:0] exRd,
    input  logic                  exMemRead,
    input  logic                  exBranchTaken,
    input  logic                  memRegWrite,
    input  logic [REG_ADDR_W-1:0] memRd,
    input  logic                  wbRegWrite,
    input  logic [REG_ADDR_W-1:0] wbRd,
    input  logic                  dmemReq,
    input  logic                  dmemAck,
    input  logic                  haltReq,
    output logic                  pcEn,
    output logic                  ifIdEn,
    output logic                  idExEn,
    output logic                  exMemEn,
    output logic                  memWbEn,
    output logic                  ifIdFlush,
    output logic                  idExFlush,
    output logic [1:0]            fwdA,
    output logic [1:0]            fwdB,
    output logic                  haltAck,
    output logic                  memTimeout,
    output logic [CNT_W-1:0]      stallCycles,
    output logic [CNT_W-1:0]      flushCount
);

    // Wide enough to hold MEM_TIMEOUT / DRAIN_CYCLES, never zero bits.
    localparam int unsigned WAIT_W  = $clog2(MEM_TIMEOUT + 2);
    localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 2);

    state_e               state_q, state_d;
    state_e               ret_q, ret_d;
    logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;

    state_e               rules_state_s;
    ctrl_t                ctrl_s;
    logic                 branch_flush_s;
    logic                 load_use_s;
    logic                 mem_stall_s;
    logic [WAIT_W-1:0]    wait_inc_s;
    logic [DRAIN_W-1:0]   drain_inc_s;

    hazard_fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .ex_rs         (exRs1),
        .mem_reg_write (memRegWrite),
        .mem_rd        (memRd),
        .wb_reg_write  (wbRegWrite),
        .wb_rd         (wbRd),
        .fwd_sel       (fwdA)
    );

    hazard_fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .ex_rs         (exRs2),
        .mem_reg_write (memRegWrite),
        .mem_rd        (memRd),
        .wb_reg_write  (wbRegWrite),
        .wb_rd         (wbRd),
        .fwd_sel       (fwdB)
    );

    assign load_use_s = exMemRead && (exRd != {REG_ADDR_W{1'b0}}) &&
                        ((idUsesRs1 && (exRd == idRs1)) || (idUsesRs2 && (exRd == idRs2)));
    assign mem_stall_s = dmemReq && !dmemAck;
    assign wait_inc_s  = wait_cnt_q + {{(WAIT_W-1){1'b0}}, 1'b1};
    assign drain_inc_s = drain_cnt_q + {{(DRAIN_W-1){1'b0}}, 1'b1};

    // State register: FSM, return state and wait/drain counters.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q     <= RUN;
            ret_q       <= RUN;
            wait_cnt_q  <= {WAIT_W{1'b0}};
            drain_cnt_q <= {DRAIN_W{1'b0}};
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            wait_cnt_q  <= wait_cnt_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Next-state and enable/flush decision. On the ack cycle of a memory wait
    // the rules of the state being returned to apply, because the frozen
    // pipeline holds the same instructions it held when the wait began.
    always_comb begin
        state_d        = state_q;
        ret_d          = ret_q;
        wait_cnt_d     = wait_cnt_q;
        drain_cnt_d    = drain_cnt_q;
        ctrl_s         = CTRL_FREEZE;
        branch_flush_s = 1'b0;

        if ((state_q == MEMWAIT) && dmemAck) begin
            rules_state_s = ret_q;
        end else begin
            rules_state_s = state_q;
        end

        case (rules_state_s)
            RUN: begin
                if (mem_stall_s) begin
                    ctrl_s     = CTRL_FREEZE;
                    ret_d      = RUN;
                    wait_cnt_d = {{(WAIT_W-1){1'b0}}, 1'b1};
                    state_d    = mem_wait_entry(MEM_TIMEOUT);
                end else if (exBranchTaken) begin
                    ctrl_s         = CTRL_BRANCH;
                    branch_flush_s = 1'b1;
                    state_d        = RUN;
                end else if (load_use_s) begin
                    ctrl_s  = CTRL_LOAD_USE;
                    state_d = RUN;
                end else if (haltReq) begin
                    ctrl_s      = CTRL_RUN;
                    drain_cnt_d = {DRAIN_W{1'b0}};
                    state_d     = (DRAIN_CYCLES == 32'd0) ? HALTED : DRAIN;
                end else begin
                    ctrl_s  = CTRL_RUN;
                    state_d = RUN;
                end
            end
            MEMWAIT: begin
                // Reached only while the access is still outstanding.
                ctrl_s = CTRL_FREEZE;
                if ((MEM_TIMEOUT != 32'd0) && (wait_inc_s == WAIT_W'(MEM_TIMEOUT))) begin
                    state_d = ERROR;
                end else begin
                    wait_cnt_d = wait_inc_s;
                    state_d    = MEMWAIT;
                end
            end
            DRAIN: begin
                if (mem_stall_s) begin
                    ctrl_s     = CTRL_FREEZE;
                    ret_d      = DRAIN;
                    wait_cnt_d = {{(WAIT_W-1){1'b0}}, 1'b1};
                    state_d    = mem_wait_entry(MEM_TIMEOUT);
                end else begin
                    // A redirect still has to load its target into the PC.
                    ctrl_s       = CTRL_DRAIN;
                    ctrl_s.pc_en = exBranchTaken;
                    if (drain_inc_s == DRAIN_W'(DRAIN_CYCLES)) begin
                        state_d = HALTED;
                    end else begin
                        drain_cnt_d = drain_inc_s;
                        state_d     = DRAIN;
                    end
                end
            end
            HALTED: begin
                ctrl_s = CTRL_FREEZE;
                if (haltReq) begin
                    state_d = HALTED;
                end else begin
                    state_d = RUN;
                end
            end
            ERROR: begin
                ctrl_s  = CTRL_FREEZE;
                state_d = ERROR;
            end
            default: begin
                ctrl_s  = CTRL_FREEZE;
                state_d = RUN;
            end
        endcase
    end

    // Output drive: reset forces bubbles into IF/ID and ID/EX with the PC held.
    always_comb begin
        if (!rstN) begin
            {pcEn, ifIdEn, idExEn, exMemEn, memWbEn, ifIdFlush, idExFlush} = CTRL_RESET;
            haltAck    = 1'b0;
            memTimeout = 1'b0;
        end else begin
            {pcEn, ifIdEn, idExEn, exMemEn, memWbEn, ifIdFlush, idExFlush} = ctrl_s;
            haltAck    = (state_q == HALTED);
            memTimeout = (state_q == ERROR);
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             stall_inc_s;

    assign stall_inc_s = !ctrl_s.pc_en && ((state_q == RUN) || (state_q == MEMWAIT));

    // Saturating increment of both performance counters.
    always_comb begin
        if (stall_inc_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (branch_flush_s && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stallCycles = stall_cnt_q;
    assign flushCount  = flush_cnt_q;
`else
    assign stallCycles = {CNT_W{1'b0}};
    assign flushCount  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl. Inputs change 1 ns after the
// rising edge; outputs are sampled 1 ns later, well clear of either edge.
module tb_hazard_ctrl;
    localparam int unsigned RW = 5;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    // {pcEn, ifIdEn, idExEn, exMemEn, memWbEn, ifIdFlush, idExFlush}
    localparam logic [6:0] E_RESET  = 7'b01111_11;
    localparam logic [6:0] E_RUN    = 7'b11111_00;
    localparam logic [6:0] E_FREEZE = 7'b00000_00;
    localparam logic [6:0] E_BRANCH = 7'b11111_11;
    localparam logic [6:0] E_LDUSE  = 7'b00111_01;
    localparam logic [6:0] E_DRAIN  = 7'b01111_10;
    localparam logic [6:0] E_DRBR   = 7'b11111_10;

    logic clk = 1'b0;
    logic rst_n;
    logic [RW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
    logic mem_reg_write, wb_reg_write, dmem_req, dmem_ack, halt_req;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush;
    logic [1:0] fwd_a, fwd_b;
    logic halt_ack, mem_timeout;
    logic [31:0] stall_cycles, flush_count;
    logic [6:0] ctrl_v;

    int n_checks = 0;
    int n_errors = 0;

    assign ctrl_v = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush};

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .rstN(rst_n),
        .idRs1(id_rs1), .idRs2(id_rs2), .idUsesRs1(id_uses_rs1), .idUsesRs2(id_uses_rs2),
        .exRs1(ex_rs1), .exRs2(ex_rs2), .exRd(ex_rd), .exMemRead(ex_mem_read),
        .exBranchTaken(ex_branch_taken),
        .memRegWrite(mem_reg_write), .memRd(mem_rd), .wbRegWrite(wb_reg_write), .wbRd(wb_rd),
        .dmemReq(dmem_req), .dmemAck(dmem_ack), .haltReq(halt_req),
        .pcEn(pc_en), .ifIdEn(if_id_en), .idExEn(id_ex_en), .exMemEn(ex_mem_en),
        .memWbEn(mem_wb_en), .ifIdFlush(if_id_flush), .idExFlush(id_ex_flush),
        .fwdA(fwd_a), .fwdB(fwd_b), .haltAck(halt_ack), .memTimeout(mem_timeout),
        .stallCycles(stall_cycles), .flushCount(flush_count)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
        {id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken} = 4'b0000;
        {mem_reg_write, wb_reg_write, dmem_req, dmem_ack, halt_req} = 5'b00000;

        // Reset values
        tick(); settle();
        check_val("rst_ctrl", {25'd0, ctrl_v}, {25'd0, E_RESET});
        check_val("rst_halt_ack", {31'd0, halt_ack}, 32'd0);
        check_val("rst_timeout", {31'd0, mem_timeout}, 32'd0);
        check_val("rst_stall_cnt", stall_cycles, 32'd0);
        check_val("rst_flush_cnt", flush_count, 32'd0);
        rst_n = 1'b1; settle();
        check_val("idle_ctrl", {25'd0, ctrl_v}, {25'd0, E_RUN});

        // Forwarding priority and the x0 exclusion
        ex_rs1 = 5'd5; ex_rs2 = 5'd5;
        mem_reg_write = 1'b1; mem_rd = 5'd5; wb_reg_write = 1'b1; wb_rd = 5'd5; settle();
        check_val("fwdA_mem", {30'd0, fwd_a}, 32'd2);
        check_val("fwdB_mem", {30'd0, fwd_b}, 32'd2);
        mem_rd = 5'd0; wb_rd = 5'd0; ex_rs1 = 5'd0; settle();
        check_val("fwdA_x0", {30'd0, fwd_a}, 32'd0);
        ex_rs1 = 5'd5; mem_rd = 5'd3; wb_rd = 5'd5; settle();
        check_val("fwdA_wb", {30'd0, fwd_a}, 32'd1);
        mem_rd = 5'd5; mem_reg_write = 1'b0; ex_rs2 = 5'd9; settle();
        check_val("fwdA_wb_nowr", {30'd0, fwd_a}, 32'd1);
        check_val("fwdB_reg", {30'd0, fwd_b}, 32'd0);
        {mem_reg_write, wb_reg_write} = 2'b00;

        // Load-use: one bubble, then normal flow
        tick();
        ex_mem_read = 1'b1; ex_rd = 5'd7; id_uses_rs2 = 1'b1; id_rs2 = 5'd7; settle();
        check_val("lduse_ctrl", {25'd0, ctrl_v}, {25'd0, E_LDUSE});
        tick();
        ex_mem_read = 1'b0; settle();
        check_val("lduse_after", {25'd0, ctrl_v}, {25'd0, E_RUN});
        id_uses_rs2 = 1'b0; ex_mem_read = 1'b1; settle();
        check_val("lduse_unused_src", {25'd0, ctrl_v}, {25'd0, E_RUN});
        ex_rd = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b1; settle();
        check_val("lduse_x0", {25'd0, ctrl_v}, {25'd0, E_RUN});
        ex_mem_read = 1'b0; id_uses_rs2 = 1'b0;

        // Taken branch in RUN
        tick();
        ex_branch_taken = 1'b1; settle();
        check_val("branch_ctrl", {25'd0, ctrl_v}, {25'd0, E_BRANCH});
        tick();
        ex_branch_taken = 1'b0; settle();
        check_val("branch_after", {25'd0, ctrl_v}, {25'd0, E_RUN});
        check_val("flush_cnt_1", flush_count, PERF_ON ? 32'd1 : 32'd0);

        // Memory wait, ack on the fourth cycle
        tick();
        dmem_req = 1'b1; settle();
        check_val("mw_c0", {25'd0, ctrl_v}, {25'd0, E_FREEZE});
        tick();
        check_val("mw_c1", {25'd0, ctrl_v}, {25'd0, E_FREEZE});
        tick();
        check_val("mw_c2", {25'd0, ctrl_v}, {25'd0, E_FREEZE});
        tick();
        dmem_ack = 1'b1; settle();
        check_val("mw_ack", {25'd0, ctrl_v}, {25'd0, E_RUN});
        tick();
        dmem_req = 1'b0; dmem_ack = 1'b0; settle();
        check_val("mw_after", {25'd0, ctrl_v}, {25'd0, E_RUN});

        // Stall and branch together: stall first, branch replayed on ack
        tick();
        dmem_req = 1'b1; ex_branch_taken = 1'b1; settle();
        check_val("stbr_stall", {25'd0, ctrl_v}, {25'd0, E_FREEZE});
        tick();
        dmem_ack = 1'b1; settle();
        check_val("stbr_ack", {25'd0, ctrl_v}, {25'd0, E_BRANCH});
        tick();
        dmem_req = 1'b0; dmem_ack = 1'b0; ex_branch_taken = 1'b0; settle();
        check_val("stbr_after", {25'd0, ctrl_v}, {25'd0, E_RUN});
        check_val("stall_cnt_5", stall_cycles, PERF_ON ? 32'd5 : 32'd0);
        check_val("flush_cnt_2", flush_count, PERF_ON ? 32'd2 : 32'd0);

        // Halt with no stalls: ack DRAIN_CYCLES cycles after DRAIN entry
        tick();
        halt_req = 1'b1; settle();
        check_val("halt_run_cycle", {25'd0, ctrl_v}, {25'd0, E_RUN});
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("drain_ctrl", {25'd0, ctrl_v}, {25'd0, E_DRAIN});
            check_val("drain_no_ack", {31'd0, halt_ack}, 32'd0);
        end
        tick();
        check_val("halted_ack", {31'd0, halt_ack}, 32'd1);
        check_val("halted_ctrl", {25'd0, ctrl_v}, {25'd0, E_FREEZE});
        tick();
        check_val("halted_hold", {31'd0, halt_ack}, 32'd1);
        halt_req = 1'b0; settle();
        check_val("halted_drop", {31'd0, halt_ack}, 32'd1);
        tick();
        check_val("resume_ctrl", {25'd0, ctrl_v}, {25'd0, E_RUN});
        check_val("resume_ack", {31'd0, halt_ack}, 32'd0);

        // Halt with a 2-cycle memory wait and a redirect inside DRAIN;
        // haltReq drops mid-drain
        halt_req = 1'b1;
        tick();
        check_val("d2_adv1", {25'd0, ctrl_v}, {25'd0, E_DRAIN});
        tick();
        dmem_req = 1'b1; settle();
        check_val("d2_stall", {25'd0, ctrl_v}, {25'd0, E_FREEZE});
        tick();
        check_val("d2_wait", {25'd0, ctrl_v}, {25'd0, E_FREEZE});
        tick();
        dmem_ack = 1'b1; halt_req = 1'b0; settle();
        check_val("d2_ack_adv2", {25'd0, ctrl_v}, {25'd0, E_DRAIN});
        tick();
        dmem_req = 1'b0; dmem_ack = 1'b0; ex_branch_taken = 1'b1; settle();
        check_val("d2_branch_adv3", {25'd0, ctrl_v}, {25'd0, E_DRBR});
        tick();
        ex_branch_taken = 1'b0; settle();
        check_val("d2_adv4_ctrl", {25'd0, ctrl_v}, {25'd0, E_DRAIN});
        check_val("d2_adv4_ack", {31'd0, halt_ack}, 32'd0);
        tick();
        check_val("d2_halted", {31'd0, halt_ack}, 32'd1);
        tick();
        check_val("d2_leave_ack", {31'd0, halt_ack}, 32'd0);
        check_val("d2_leave_ctrl", {25'd0, ctrl_v}, {25'd0, E_RUN});

        // Watchdog: 16 unacknowledged cycles lead to ERROR
        dmem_req = 1'b1; settle();
        check_val("to_c0", {25'd0, ctrl_v}, {25'd0, E_FREEZE});
        for (int i = 1; i < 16; i++) begin
            tick();
            check_val("to_waiting", {31'd0, mem_timeout}, 32'd0);
        end
        tick();
        check_val("to_error", {31'd0, mem_timeout}, 32'd1);
        check_val("to_error_ctrl", {25'd0, ctrl_v}, {25'd0, E_FREEZE});
        dmem_req = 1'b0; dmem_ack = 1'b1;
        tick(); tick();
        check_val("to_sticky", {31'd0, mem_timeout}, 32'd1);
        dmem_ack = 1'b0;
        rst_n = 1'b0; settle();
        check_val("to_rst_ctrl", {25'd0, ctrl_v}, {25'd0, E_RESET});
        check_val("to_rst_flag", {31'd0, mem_timeout}, 32'd0);
        tick();
        rst_n = 1'b1; settle();
        check_val("to_cleared", {31'd0, mem_timeout}, 32'd0);
        check_val("to_cleared_ctrl", {25'd0, ctrl_v}, {25'd0, E_RUN});

        // Reset in the middle of a memory wait
        dmem_req = 1'b1;
        tick(); tick();
        check_val("mwrst_wait", {25'd0, ctrl_v}, {25'd0, E_FREEZE});
        rst_n = 1'b0; settle();
        check_val("mwrst_ctrl", {25'd0, ctrl_v}, {25'd0, E_RESET});
        tick();
        rst_n = 1'b1; dmem_req = 1'b0; settle();
        check_val("mwrst_run", {25'd0, ctrl_v}, {25'd0, E_RUN});
        check_val("mwrst_timeout", {31'd0, mem_timeout}, 32'd0);
        check_val("mwrst_stall_cnt", stall_cycles, 32'd0);
        check_val("mwrst_flush_cnt", flush_count, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
